// File: rtl/sram_ctrl_mp.sv
// sram_ctrl_mp
// Multi-channel controller for an external asynchronous SRAM. NCH request
// channels are arbitrated round-robin. One complete SRAM read or write runs
// at a time, with a programmable access length and bus turnaround.
//
// Parameters
//   AW    SRAM address width
//   DW    data width (multiple of 8)
//   NCH   number of request channels (>= 1)
//   WAIT  access-phase length in cycles (0 behaves as 1)
//   TURN  idle cycles after each access before the next grant
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   req, we         per-channel request level and write select
//   addr, wdata, be per-channel address, write data, byte enables (packed by channel)
//   ack             one-cycle completion pulse to the served channel
//   rdata           last read data, held until the next read completes
//   busy            controller is not idle
//   sram_*          SRAM pins; sram_data is driven only during writes
module sram_ctrl_mp #(
    parameter int AW   = 20,
    parameter int DW   = 32,
    parameter int NCH  = 2,
    parameter int WAIT = 3,
    parameter int TURN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        we,
    input  logic [NCH*AW-1:0]     addr,
    input  logic [NCH*DW-1:0]     wdata,
    input  logic [NCH*DW/8-1:0]   be,
    output logic [NCH-1:0]        ack,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    output logic [AW-1:0]         sram_addr,
    inout  wire  [DW-1:0]         sram_data,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [DW/8-1:0]       sram_be_n
);

    localparam int BW   = DW / 8;
    localparam int WEFF = (WAIT < 1) ? 1 : WAIT;
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNTW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_TURN
    } state_t;

    state_t            state;
    logic [CW-1:0]     ptr;
    logic [CW-1:0]     gnt;
    logic              lat_we;
    logic [DW-1:0]     lat_wdata;
    logic              drive;
    logic [CNTW-1:0]   cnt;

    logic              pick_valid;
    logic [CW-1:0]     pick_idx;

    // Round-robin pick: scan from the pointer upward; iterating from the far
    // end means the closest requester to the pointer is the last one written.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NCH]) begin
                pick_valid = 1'b1;
                pick_idx   = CW'((int'(ptr) + i) % NCH);
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign sram_data = drive ? lat_wdata : {DW{1'bz}};

    // Controller FSM. Pin values are registered one edge ahead, so each
    // state's strobes are already valid during its first cycle. The address
    // is loaded at grant and we_n only falls one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            gnt       <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            drive     <= 1'b0;
            cnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= '1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        state     <= S_SETUP;
                        gnt       <= pick_idx;
                        ptr       <= CW'((int'(pick_idx) + 1) % NCH);
                        lat_we    <= we[pick_idx];
                        lat_wdata <= wdata[int'(pick_idx)*DW +: DW];
                        sram_addr <= addr[int'(pick_idx)*AW +: AW];
                        sram_ce_n <= 1'b0;
                        sram_we_n <= 1'b1;
                        if (we[pick_idx]) begin
                            sram_oe_n <= 1'b1;
                            sram_be_n <= ~be[int'(pick_idx)*BW +: BW];
                            drive     <= 1'b1;
                        end else begin
                            sram_oe_n <= 1'b0;
                            sram_be_n <= '0;
                            drive     <= 1'b0;
                        end
                    end
                end
                S_SETUP: begin
                    state <= S_ACCESS;
                    cnt   <= CNTW'(WEFF - 1);
                    if (lat_we) begin
                        sram_we_n <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (cnt == '0) begin
                        state      <= S_DONE;
                        ack[gnt]   <= 1'b1;
                        if (!lat_we) begin
                            rdata <= sram_data;
                        end
                        sram_ce_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        sram_be_n  <= '1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    // Write data was held through DONE for SRAM hold time.
                    ack   <= '0;
                    drive <= 1'b0;
                    if (TURN == 0) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_TURN;
                        cnt   <= CNTW'(TURN - 1);
                    end
                end
                S_TURN: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl_mp.sv
// tb_sram_ctrl_mp
// Self-checking bench for sram_ctrl_mp. A behavioural SRAM sits on the pins;
// a reference memory plus a scoreboard queue hold the expected result of each
// issued request, and a monitor pops and compares on every ack. A second
// instance with WAIT=1, TURN=0 and one channel covers back-to-back reads.
module tb_sram_ctrl_mp;

    localparam int AW     = 20;
    localparam int DW     = 32;
    localparam int NCH    = 2;
    localparam int WAIT   = 3;
    localparam int TURN   = 1;
    localparam int PERIOD = 3 + WAIT + TURN;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic [NCH*4-1:0]  be;
    logic [NCH-1:0]    ack;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [AW-1:0]     sram_addr;
    wire  [DW-1:0]     sram_data;
    logic              sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]        sram_be_n;

    logic              f_req, f_we;
    logic [AW-1:0]     f_addr;
    logic [DW-1:0]     f_wdata;
    logic [3:0]        f_be;
    logic [0:0]        f_ack;
    logic [DW-1:0]     f_rdata;
    logic              f_busy;
    logic [AW-1:0]     f_sram_addr;
    wire  [DW-1:0]     f_data;
    logic              f_ce_n, f_oe_n, f_we_n;
    logic [3:0]        f_be_n;

    always #5 clk = ~clk;

    sram_ctrl_mp #(.AW(AW), .DW(DW), .NCH(NCH), .WAIT(WAIT), .TURN(TURN)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .ack(ack), .rdata(rdata), .busy(busy), .sram_addr(sram_addr),
        .sram_data(sram_data), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    sram_ctrl_mp #(.AW(AW), .DW(DW), .NCH(1), .WAIT(1), .TURN(0)) dut_fast (
        .clk(clk), .rst(rst), .req(f_req), .we(f_we), .addr(f_addr), .wdata(f_wdata),
        .be(f_be), .ack(f_ack), .rdata(f_rdata), .busy(f_busy), .sram_addr(f_sram_addr),
        .sram_data(f_data), .sram_ce_n(f_ce_n), .sram_oe_n(f_oe_n),
        .sram_we_n(f_we_n), .sram_be_n(f_be_n)
    );

    // Behavioural SRAM for the main instance (512 words visible).
    logic [DW-1:0] sram_mem [0:511];
    logic          pl_en;
    logic [8:0]    pl_addr;
    logic [DW-1:0] pl_data;

    assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr[8:0]] : {DW{1'bz}};

    always @(posedge clk) begin
        if (pl_en) begin
            sram_mem[pl_addr] <= pl_data;
        end else if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) begin
                    sram_mem[sram_addr[8:0]][b*8 +: 8] <= sram_data[b*8 +: 8];
                end
            end
        end
    end

    // SRAM for the fast instance returns a tag plus the address.
    assign f_data = (!f_ce_n && !f_oe_n && f_we_n) ? {12'hC00, f_sram_addr} : {DW{1'bz}};

    // Reference model and scoreboard.
    typedef struct {
        int            ch;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    be;
        longint        exp_cyc;
    } item_t;

    item_t           sb[$];
    logic [DW-1:0]   ref_mem [int];
    int              ptr_model = 0;
    longint          cyc = 0;
    int              ack_seen = 0;
    int              pass_cnt = 0;
    int              total_cnt = 0;
    int              bus_err = 0;
    int              f_bus_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] initVal(int a);
        if (a == 'h123) return 32'hDEADBEEF;
        if (a == 'h010) return 32'h11111111;
        return 32'h5A000000 ^ (a * 32'h00010203);
    endfunction

    function automatic logic [DW-1:0] refRead(int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return initVal(a);
    endfunction

    function automatic void refWrite(int a, logic [DW-1:0] d, logic [3:0] b);
        logic [DW-1:0] v;
        v = refRead(a);
        for (int i = 0; i < 4; i++) begin
            if (b[i]) v[i*8 +: 8] = d[i*8 +: 8];
        end
        ref_mem[a] = v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pin sanity every cycle, full compare on every ack.
    item_t mon_h;
    int    we_low = 0;
    int    oe_low = 0;
    int    pin_err = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                we_low = 0; oe_low = 0; pin_err = 0;
                continue;
            end
            if (f_oe_n && f_data !== {DW{1'bz}}) f_bus_err++;
            if (f_we_n !== 1'b1) f_bus_err++;
            if (sb.size() > 0 && !sb[0].we && sram_oe_n && sram_data !== {DW{1'bz}}) bus_err++;
            if (sb.size() > 0 && !sram_ce_n) begin
                mon_h = sb[0];
                if (sram_addr !== mon_h.addr) pin_err++;
                if (mon_h.we) begin
                    if (sram_be_n !== ~mon_h.be) pin_err++;
                    if (sram_oe_n !== 1'b1) pin_err++;
                    if (sram_data !== mon_h.data) pin_err++;
                    if (sram_we_n === 1'b0) we_low++;
                end else begin
                    if (sram_be_n !== 4'b0000) pin_err++;
                    if (sram_we_n !== 1'b1) pin_err++;
                    if (sram_oe_n === 1'b0) oe_low++;
                end
            end
            if (ack !== '0) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_ack", 64'(ack), 64'd0);
                end else begin
                    mon_h = sb.pop_front();
                    checkOutput("ack_channel", 64'(ack), 64'(1 << mon_h.ch));
                    checkOutput("ack_cycle", 64'(cyc), 64'(mon_h.exp_cyc));
                    checkOutput("pin_errors", 64'(pin_err), 64'd0);
                    if (mon_h.we) begin
                        checkOutput("we_low_cycles", 64'(we_low), 64'(WAIT));
                    end else begin
                        checkOutput("rdata", 64'(rdata), 64'(mon_h.data));
                        checkOutput("oe_low_cycles", 64'(oe_low), 64'(WAIT + 1));
                    end
                end
                ack_seen++;
                we_low = 0; oe_low = 0; pin_err = 0;
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic waitAcks(input int target);
        int n = 0;
        while (ack_seen < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (ack_seen < target) checkOutput("ack_timeout", 64'(ack_seen), 64'(target));
    endtask

    // Issue one request on a channel; optionally scramble its inputs mid-access.
    task automatic applyStimulus(input int ch, input bit w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [3:0] b, input bit perturb);
        item_t it;
        int    target;
        waitIdle();
        it.ch = ch; it.we = w; it.addr = a; it.be = b;
        it.exp_cyc = cyc + 2 + WAIT;
        if (w) begin
            it.data = d;
            refWrite(int'(a), d, b);
        end else begin
            it.data = refRead(int'(a));
        end
        sb.push_back(it);
        target = ack_seen + 1;
        req[ch] = 1'b1;
        we[ch]  = w;
        addr[ch*AW +: AW]  = a;
        wdata[ch*DW +: DW] = d;
        be[ch*4 +: 4]      = b;
        if (perturb) begin
            repeat (3) @(negedge clk);
            we[ch] = 1'($urandom);
            addr[ch*AW +: AW]  = AW'($urandom);
            wdata[ch*DW +: DW] = $urandom;
            be[ch*4 +: 4]      = 4'($urandom);
        end
        waitAcks(target);
        req[ch] = 1'b0;
        ptr_model = (ch + 1) % NCH;
    endtask

    // Both channels request continuously; expect strict alternation.
    task automatic contention(input int grants);
        item_t         it;
        int            first;
        longint        base;
        logic [AW-1:0] ca [NCH];
        ca[0] = 20'h00123;
        ca[1] = 20'h00010;
        waitIdle();
        base  = cyc;
        first = ptr_model;
        for (int k = 0; k < grants; k++) begin
            it.ch = (first + k) % NCH;
            it.we = 1'b0;
            it.addr = ca[it.ch];
            it.be = 4'h0;
            it.data = refRead(int'(ca[it.ch]));
            it.exp_cyc = base + 2 + WAIT + longint'(k) * PERIOD;
            sb.push_back(it);
        end
        for (int c = 0; c < NCH; c++) begin
            we[c] = 1'b0;
            addr[c*AW +: AW] = ca[c];
        end
        req = '1;
        waitAcks(ack_seen + grants);
        req = '0;
        ptr_model = (first + grants) % NCH;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            n;
        int            k;
        longint        base;
        logic [DW-1:0] wd;

        rst = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        f_req = 1'b0; f_we = 1'b0; f_addr = '0; f_wdata = '0; f_be = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        // Preload the SRAM model while reset is held.
        for (int a = 0; a < 512; a++) begin
            @(negedge clk);
            pl_en = 1'b1;
            pl_addr = 9'(a);
            pl_data = initVal(a);
        end
        @(negedge clk);
        pl_en = 1'b0;

        checkOutput("reset_ce_n", 64'(sram_ce_n), 64'd1);
        checkOutput("reset_oe_n", 64'(sram_oe_n), 64'd1);
        checkOutput("reset_we_n", 64'(sram_we_n), 64'd1);
        checkOutput("reset_be_n", 64'(sram_be_n), 64'hF);
        checkOutput("reset_addr", 64'(sram_addr), 64'd0);
        checkOutput("reset_bus_hiz", 64'(sram_data === {DW{1'bz}}), 64'd1);
        checkOutput("reset_ack", 64'(ack), 64'd0);
        checkOutput("reset_rdata", 64'(rdata), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_fast_busy", 64'(f_busy), 64'd0);

        @(negedge clk);
        rst = 1'b1;

        $display("[TB] directed read and byte write");
        applyStimulus(0, 1'b0, 20'h00123, 32'h0, 4'h0, 1'b0);
        applyStimulus(1, 1'b1, 20'h00010, 32'hA5A5A5A5, 4'b0101, 1'b0);
        applyStimulus(0, 1'b0, 20'h00010, 32'h0, 4'h0, 1'b0);

        $display("[TB] contention");
        contention(4);

        $display("[TB] inputs changed mid-access");
        applyStimulus(0, 1'b1, 20'h00040, 32'h12345678, 4'hF, 1'b1);
        applyStimulus(1, 1'b0, 20'h00040, 32'h0, 4'h0, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 30; i++) begin
            applyStimulus(int'($urandom_range(0, NCH - 1)), 1'($urandom),
                          AW'(32'h20 + $urandom_range(0, 15)), $urandom,
                          4'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] reset during write");
        waitIdle();
        wd = $urandom;
        req[0] = 1'b1; we[0] = 1'b1;
        addr[0 +: AW] = 20'h00030;
        wdata[0 +: DW] = wd;
        be[0 +: 4] = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sram_we_n !== 1'b0 && n < 20);
        checkOutput("write_started", 64'(sram_we_n), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("midreset_we_n", 64'(sram_we_n), 64'd1);
        checkOutput("midreset_ce_n", 64'(sram_ce_n), 64'd1);
        checkOutput("midreset_bus_hiz", 64'(sram_data === {DW{1'bz}}), 64'd1);
        checkOutput("midreset_ack", 64'(ack), 64'd0);
        req = '0;
        sb.delete();
        ptr_model = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("busy_after_reset", 64'(busy), 64'd0);
        applyStimulus(0, 1'b0, 20'h00030, 32'h0, 4'h0, 1'b0);

        $display("[TB] back-to-back reads, WAIT=1 TURN=0");
        @(negedge clk);
        f_addr = 20'h00ABC;
        f_req = 1'b1;
        base = cyc;
        k = 0;
        n = 0;
        while (k < 5 && n < 60) begin
            @(negedge clk);
            n++;
            if (f_ack[0]) begin
                checkOutput("fast_ack_cycle", 64'(cyc), 64'(base + 3 + longint'(k) * 4));
                checkOutput("fast_rdata", 64'(f_rdata), 64'({12'hC00, f_addr}));
                k++;
            end
        end
        f_req = 1'b0;
        checkOutput("fast_ack_count", 64'(k), 64'd5);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        checkOutput("bus_driven_on_read", 64'(bus_err), 64'd0);
        checkOutput("fast_bus_driven", 64'(f_bus_err), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sram_ctrl_mp.md
# sram_ctrl_mp

Multi-channel controller for the external asynchronous SRAM, the parametrised successor of the single-port SRAM controller. It arbitrates round-robin among NCH request channels and runs one complete SRAM read or write at a time. Address and data widths, access wait states and bus turnaround are parametrised, and writes carry per-byte enables. It sits between the on-chip masters (sample player, loader, display) and the board SRAM pins.

## Interface
- AW, default 20: SRAM address width.
- DW, default 32: data width; must be a multiple of 8.
- NCH, default 2: number of request channels, at least 1.
- WAIT, default 3: access-phase length in cycles; 0 is treated as 1.
- TURN, default 1: idle cycles after each access before the next grant; 0 allowed.
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-low reset.
- req, input, NCH: per-channel request, level.
- we, input, NCH: per-channel write (1) or read (0).
- addr, input, NCH*AW: per-channel address; channel k uses bits [k*AW +: AW].
- wdata, input, NCH*DW: per-channel write data.
- be, input, NCH*DW/8: per-channel byte enables, active high; applies to writes only.
- ack, output, NCH: one-cycle completion pulse to the granted channel.
- rdata, output, DW: read data; valid in the ack cycle and held until the next read completes.
- busy, output, 1: high whenever state is not IDLE.
- sram_addr, output, AW: SRAM address.
- sram_data, inout, DW: SRAM data; driven only during writes, otherwise hi-Z.
- sram_ce_n, sram_oe_n, sram_we_n, output, 1 each: active-low strobes.
- sram_be_n, output, DW/8: active-low byte lanes.

## Operation
- States: IDLE, SETUP, ACCESS, DONE, TURN.
- IDLE, any req high: grant one channel and latch its we, addr, wdata and be; go to SETUP. Input changes after the grant are ignored until the next grant.
- Arbitration is round-robin. The priority pointer resets to channel 0. After channel k is served, channel (k+1) mod NCH has highest priority.
- SETUP (1 cycle):
  - sram_addr = latched address; sram_ce_n = 0.
  - Read: sram_oe_n = 0, sram_we_n = 1, sram_be_n = 0, bus hi-Z.
  - Write: sram_oe_n = 1, sram_we_n = 1, sram_be_n = ~be, data driven.
- ACCESS (WAIT cycles, down-counter):
  - Read: strobes as in SETUP; rdata captures sram_data at the clock edge that ends the last ACCESS cycle.
  - Write: sram_we_n = 0; data and byte lanes held.
- DONE (1 cycle):
  - ack[granted] = 1; sram_ce_n, sram_oe_n, sram_we_n and sram_be_n all return to 1.
  - sram_addr is held.
  - On a write, sram_data stays driven during DONE for hold time and is released at its end.
- DONE then TURN for TURN cycles (all strobes high, bus hi-Z), then IDLE. With TURN = 0, DONE goes directly to IDLE.
- req is level-sensitive. A master must deassert req in the cycle after ack unless it wants another access. A req still high in IDLE is a new request.
- A single channel requesting continuously is served back-to-back. Other requesters are never starved: each waits at most NCH-1 accesses.

## Timing
- Reset values:
  - sram_ce_n, sram_oe_n, sram_we_n = 1; sram_be_n all 1; sram_data hi-Z; sram_addr = 0.
  - ack = 0; rdata = 0; busy = 0; state IDLE; pointer 0.
- Reset mid-access: outputs take their reset values immediately (asynchronous). The transaction is dropped and no ack is issued.
- req sampled in IDLE at cycle t: SETUP at t+1, ACCESS t+2..t+1+WAIT, ack at t+2+WAIT.
- Minimum access period is 3+WAIT+TURN cycles; 7 with the defaults.
- Strobe outputs come straight from registered state or decoded state, with no input-to-output combinational path.
- sram_we_n never falls in the same cycle as an address change. sram_data is never driven while sram_oe_n = 0.

## Test plan
- Reset: hold rst = 0 mid-write. Required: sram_we_n = 1, bus hi-Z and ack = 0 immediately; after release, busy = 0.
- Single read, defaults: SRAM model returns 0xDEADBEEF at address 0x00123. req[0] at cycle t gives ack[0] at t+5 with rdata = 0xDEADBEEF, and sram_oe_n low for cycles t+1..t+4.
- Byte write: ch1 writes 0xA5A5A5A5 with be = 4'b0101 to 0x00010 over a model holding 0x11111111. Required: sram_be_n = 4'b1010 during SETUP/ACCESS, sram_we_n low for exactly 3 cycles, read-back 0x11A511A5.
- Contention: req = 2'b11 held continuously. Required: grants alternate ch0, ch1, ch0, ch1, with ack pulses 7 cycles apart.
- WAIT = 1, TURN = 0: back-to-back reads on ch0. Required: one ack every 4 cycles, and the bus is never driven.
- Illegal requests during an access: change ch0's addr and wdata mid-access. Required: the SRAM sees only the values latched at grant.
